// File: rtl/matriz_scan_receptor.sv
// Scan-matrix receiver: watches a 5-column x 7-row multiplexed display scan
// and rebuilds the full frame. Columns are debounced by a stability counter.
// A small FSM (HUNT/ACQ/DONE) checks that the columns arrive in order 0..4.
// Each complete in-order scan is published on frame.
//
// Ports:
//   clk          system clock, rising edge
//   clr          synchronous active-high reset
//   m_col[4:0]   column strobe, one-hot active-high, all-zero = blanking
//   m_line[6:0]  row data for the strobed column (bit r = row r)
//   frame[34:0]  last complete frame, bit 5*r+c = row r, column c
//   frame_valid  one-cycle pulse when frame updates
//   frame_err    one-cycle pulse on a scan protocol violation
//   col_ok[4:0]  columns captured so far for the frame in progress
//   sync         high while in ACQ
module matriz_scan_receptor #(
  parameter int unsigned STABLE_CYC = 4,
  parameter bit          LINE_INV   = 1'b0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [4:0]  m_col,
  input  logic [6:0]  m_line,
  output logic [34:0] frame,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [4:0]  col_ok,
  output logic        sync
);

  typedef enum logic [1:0] {StHunt, StAcq, StDone} state_e;

  localparam logic [7:0] StableMax = 8'(STABLE_CYC);

  state_e      state_q, state_d;
  logic [4:0]  s_col_q, prev_col_q;
  logic [6:0]  s_line_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [34:0] shadow_q, shadow_d;
  logic [34:0] frame_q, frame_d;
  logic        frame_valid_q, frame_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [4:0]  col_ok_q, col_ok_d;

  logic        accept;
  logic        one_hot;
  logic        multi_hot;
  logic [2:0]  col_idx;
  logic [6:0]  line_cap;
  logic        latch_col;

  // cnt_d is the number of consecutive cycles s_col_q has held its current
  // value, including this one; acceptance fires on the cycle it first hits
  // the threshold, so a long dwell is accepted only once.
  always_comb begin
    cnt_d = cnt_q;
    if (s_col_q != prev_col_q) begin
      cnt_d = 8'd1;
    end else if (cnt_q < StableMax) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign accept = (cnt_d == StableMax) && (cnt_q != StableMax);

  always_comb begin
    one_hot = 1'b0;
    col_idx = 3'd0;
    unique case (s_col_q)
      5'b00001: begin one_hot = 1'b1; col_idx = 3'd0; end
      5'b00010: begin one_hot = 1'b1; col_idx = 3'd1; end
      5'b00100: begin one_hot = 1'b1; col_idx = 3'd2; end
      5'b01000: begin one_hot = 1'b1; col_idx = 3'd3; end
      5'b10000: begin one_hot = 1'b1; col_idx = 3'd4; end
      default:  ;
    endcase
  end

  assign multi_hot = (s_col_q != 5'b00000) && !one_hot;
  assign line_cap  = LINE_INV ? ~s_line_q : s_line_q;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    col_ok_d      = col_ok_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    latch_col     = 1'b0;

    case (state_q)
      StDone: begin
        frame_d       = shadow_q;
        frame_valid_d = 1'b1;
        col_ok_d      = 5'b00000;
        ptr_d         = 3'd0;
        state_d       = StAcq;
      end
      StHunt, StAcq: begin
        if (accept && multi_hot) begin
          frame_err_d = 1'b1;
          col_ok_d    = 5'b00000;
          ptr_d       = 3'd0;
          state_d     = StHunt;
        end else if (accept && one_hot) begin
          if (state_q == StHunt || ptr_q == 3'd0) begin
            // Looking for a frame start: anything but column 0 is ignored.
            if (col_idx == 3'd0) begin
              latch_col = 1'b1;
              col_ok_d  = 5'b00001;
              ptr_d     = 3'd1;
              state_d   = StAcq;
            end
          end else if (col_idx == ptr_q) begin
            latch_col         = 1'b1;
            col_ok_d[col_idx] = 1'b1;
            if (col_idx == 3'd4) begin
              state_d = StDone;
            end else begin
              ptr_d = ptr_q + 3'd1;
            end
          end else begin
            frame_err_d = 1'b1;
            if (col_idx == 3'd0) begin
              // Out-of-order column 0 is treated as the start of a new frame.
              latch_col = 1'b1;
              col_ok_d  = 5'b00001;
              ptr_d     = 3'd1;
              state_d   = StAcq;
            end else begin
              col_ok_d = 5'b00000;
              ptr_d    = 3'd0;
              state_d  = StHunt;
            end
          end
        end
      end
      default: begin
        col_ok_d = 5'b00000;
        ptr_d    = 3'd0;
        state_d  = StHunt;
      end
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    if (latch_col) begin
      for (int unsigned r = 0; r < 7; r++) begin
        shadow_d[5 * r + 32'(col_idx)] = line_cap[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q       <= StHunt;
      s_col_q       <= 5'b00000;
      prev_col_q    <= 5'b00000;
      s_line_q      <= 7'h00;
      cnt_q         <= 8'd0;
      ptr_q         <= 3'd0;
      shadow_q      <= 35'h0;
      frame_q       <= 35'h0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      col_ok_q      <= 5'b00000;
    end else begin
      state_q       <= state_d;
      s_col_q       <= m_col;
      prev_col_q    <= s_col_q;
      s_line_q      <= m_line;
      cnt_q         <= cnt_d;
      ptr_q         <= ptr_d;
      shadow_q      <= shadow_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      col_ok_q      <= col_ok_d;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign col_ok      = col_ok_q;
  assign sync        = (state_q == StAcq);

endmodule

// File: doc/matriz_scan_receptor.md
MATRIZ_SCAN_RECEPTOR -- requirements
Module: matriz_scan_receptor

Interface
REQ-001 The block SHALL be a single-clock design; reset is synchronous and active-high.
REQ-002 Parameter STABLE_CYC, default 4: consecutive identical samples required before a column is accepted (legal range 2..255).
REQ-003 Parameter LINE_INV, default 0: when 1, m_line is inverted before capture.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 clr  input  1  synchronous active-high reset.
REQ-006 m_col  input  5  column strobe from the scan driver, one-hot active-high; all-zero means blanking.
REQ-007 m_line  input  7  row data for the strobed column; bit r is row r.
REQ-008 frame  output  35  last complete captured frame; bit 5*r+c is row r, column c.
REQ-009 frame_valid  output  1  one-cycle pulse when frame updates.
REQ-010 frame_err  output  1  one-cycle pulse on a scan protocol violation.
REQ-011 col_ok  output  5  per-column captured flags for the frame in progress.
REQ-012 sync  output  1  high while the block is in state ACQ.

Function
REQ-013 m_col and m_line SHALL be registered once (s_col, s_line); all decisions use the registered copies.
REQ-014 A stability counter SHALL count consecutive cycles with s_col unchanged; it reloads to 1 on any change and saturates at STABLE_CYC.
REQ-015 A column SHALL be accepted exactly once per dwell, on the cycle the counter first reaches STABLE_CYC with s_col one-hot; the s_line value of that cycle (after LINE_INV) is latched into the shadow bits for that column.
REQ-016 s_col all-zero SHALL be treated as blanking: no capture, no error, expected-column pointer unchanged.
REQ-017 s_col with two or more bits set, once stable for STABLE_CYC cycles, SHALL pulse frame_err and force state HUNT.
REQ-018 FSM states SHALL be HUNT, ACQ and DONE; the reset state is HUNT.
REQ-019 HUNT: an accepted column 0 latches its shadow bits, sets col_ok to 00001 and moves to ACQ with expected column 1; any other accepted column is ignored without error.
REQ-020 ACQ: an accepted column equal to the expected column latches it, sets its col_ok bit and increments the pointer; acceptance of column 4 moves to DONE.
REQ-021 ACQ: an accepted column other than the expected one SHALL pulse frame_err and clear col_ok. If it is column 0, it restarts capture as in HUNT; otherwise the FSM moves to HUNT.
REQ-022 DONE (one cycle): frame SHALL load all 35 shadow bits, frame_valid pulses, col_ok clears, and the FSM moves to ACQ expecting column 0.
REQ-023 ACQ expecting column 0 SHALL behave as HUNT without error for non-zero columns; a scan that starts mid-frame is not a fault after the first frame.
REQ-024 frame SHALL hold its value between frame_valid pulses; a partial or aborted frame never alters frame.
REQ-025 Latency: frame_valid SHALL assert exactly 2 clk cycles after the acceptance edge of column 4, counting the DONE cycle.
REQ-026 frame_valid and frame_err SHALL never be high in the same cycle.

Reset
REQ-027 With clr high at a clock edge, the following SHALL apply:
- frame = 0, frame_valid = 0, frame_err = 0, col_ok = 0, sync = 0;
- shadow = 0, counter = 0, s_col = 0, s_line = 0;
- state = HUNT.
REQ-028 clr SHALL take precedence over all other activity, including mid-frame capture and the DONE cycle; no frame_valid is emitted for the interrupted frame.

Verification
REQ-029 Clean scan, STABLE_CYC=4, each column held 8 cycles:
- stimulus: columns 0..4 with m_line = 7'h7F, 7'h00, 7'h55, 7'h2A, 7'h01;
- response: one frame_valid pulse, and frame bits 5r+c match m_line[r] of column c.
REQ-030 Glitch rejection: column 2 held for only 3 cycles, then column 3 -> not accepted, frame_err pulses, sync drops, frame is unchanged.
REQ-031 Mid-frame entry: scan starts at column 3 -> no error and no frame_valid until columns 0..4 complete; the first frame_valid follows the column-4 acceptance of the next full scan.
REQ-032 Multi-hot: m_col = 5'b00011 held for 6 cycles -> one frame_err pulse, state HUNT, col_ok = 0.
REQ-033 LINE_INV=1: m_line = 7'h7F on every column -> frame = 35'h0.
REQ-034 clr asserted during column 3 of a frame, then a full scan -> no frame_valid for the aborted frame, and the next frame is captured correctly.
